// File: rtl/calc_pkg.sv
// Shared constants for the calculator display path.
// State encoding and packed-BCD digit width.
package calc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int BCD_W = 4;

endpackage

// File: rtl/bcd_seq_converter_add3.sv
// Double-dabble correction cell for one BCD digit.
// Adds 3 when the digit is 5 or more, so the next shift carries correctly.
module bcd_seq_converter_add3
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  // Digit correction ahead of the shift.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_W'(5)) begin
      digit_o = digit_i + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// One bit per clock; start/busy/done handshake.
module bcd_seq_converter
  import calc_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int CNT_W   = $clog2(BIN_W + 1);

  // 10^D > 2^B  <=>  D*log2(10) > B; scaled integer compare.
  localparam longint LHS = longint'(DIGITS) * 64'd3321928;
  localparam longint RHS = longint'(BIN_W) * 64'd1000000;

  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bcd_seq_converter: BIN_W must be at least 2");
  end

  if (LHS <= RHS) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small for BIN_W");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_TOT-1:0] w_q, w_d;
  logic [BCD_TOT-1:0] bcd_q, bcd_d;

  logic [BCD_TOT-1:0] w_corr;
  logic [BCD_TOT-1:0] w_shift;
  logic [BIN_W-1:0]   bin_shift;
  logic               load;
  logic               unused_w_msb;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_seq_converter_add3 u_add3 (
      .digit_i (w_q[i*BCD_W +: BCD_W]),
      .digit_o (w_corr[i*BCD_W +: BCD_W])
    );
  end

  // The corrected MSB is shifted out; it is always zero for legal sizing.
  assign unused_w_msb = w_corr[BCD_TOT-1];
  assign w_shift      = {w_corr[BCD_TOT-2:0], bin_q[BIN_W-1]};
  assign bin_shift    = {bin_q[BIN_W-2:0], 1'b0};

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    w_d     = w_q;
    bcd_d   = bcd_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load = start;
      end
      ST_SHIFT: begin
        bin_d = bin_shift;
        w_d   = w_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          bcd_d   = w_shift;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        load    = start;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (load) begin
      state_d = ST_SHIFT;
      bin_d   = bin_in;
      w_d     = '0;
      cnt_d   = CNT_W'(BIN_W);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      w_q     <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      w_q     <= w_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter.
// Driver queues expected results; monitor checks at negedge.
module tb_bcd_seq_converter;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   bin_in = '0;
  logic          busy;
  logic          done;
  logic [BW-1:0] bcd_out;

  typedef struct {
    logic [BW-1:0] bcd;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  logic [BW-1:0] exp_bcd = '0;

  bcd_seq_converter #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] to_bcd(int unsigned v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, want, cyc);
    end
  endtask

  // Monitor: pop expected results when done is due; check every cycle.
  always @(negedge clk) begin
    logic busy_exp;
    logic done_exp;
    if (rst) begin
      q.delete();
      exp_bcd = '0;
    end else begin
      busy_exp = 1'b0;
      foreach (q[i]) begin
        if (cyc >= q[i].due - BIN_W && cyc < q[i].due) busy_exp = 1'b1;
      end
      done_exp = (q.size() > 0) && (q[0].due == cyc);
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("done", 32'(done), 32'(done_exp));
      if (done_exp) begin
        exp_bcd = q[0].bcd;
        void'(q.pop_front());
      end
      chk("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int unsigned v);
    int n;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL launch_timeout value=%0d", v);
      return;
    end
    start  = 1'b1;
    bin_in = 16'(v);
    e.bcd  = to_bcd(v);
    e.due  = cyc + 1 + BIN_W;
    q.push_back(e);
    step();
    start  = 1'b0;
    bin_in = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout pending=%0d", q.size());
      q.delete();
    end
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    step();

    launch(0);
    drain();
    launch(1234);
    launch(65535);
    launch(9);
    drain();

    launch(42);
    repeat (5) step();
    start  = 1'b1;
    bin_in = 16'd7;
    step();
    start  = 1'b0;
    drain();

    launch(100);
    launch(999);
    drain();

    launch(5000);
    repeat (7) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    repeat (25) step();
    launch(5000);
    drain();

    for (int k = 0; k < 30; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      launch($urandom_range(0, 65535));
      if (gap != 0) begin
        drain();
        repeat (gap) step();
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
